// File: rtl/mem_stage.sv
// Memory-access stage: turns the ALU result into a load/store on a req/ack data port,
// extends load data, and emits one registered writeback record per accepted instruction.
module mem_stage #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InValid,
    input  logic [3:0]  InOp,
    input  logic [31:0] ALUOut,
    input  logic        ALUEn,
    input  logic        RegWrite,
    input  logic [4:0]  Dest,
    input  logic [31:0] StoreData,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBE,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        WbValid,
    output logic        WbWrite,
    output logic [4:0]  WbDest,
    output logic [31:0] WbData,
    output logic        AdErr,
    output logic        BusErr,
    output logic        dbg_state
);

    // Handshake: the stage accepts an instruction on an edge where InValid=1 and Stall=0;
    // a memory transaction holds MemReq and its fields stable until the edge sampling MemAck=1.
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LH  = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    function automatic logic is_mem(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: is_mem = 1'b1;
            default: is_mem = 1'b0;
        endcase
    endfunction

    // 0 = byte, 1 = halfword, 2 = word
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
            default:              op_size = 2'd2;
        endcase
    endfunction

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [3:0]  op_q, op_n;
    logic [1:0]  lo_q, lo_n;
    logic [4:0]  dest_q, dest_n;
    logic        rw_q, rw_n;
    logic        req_n, we_n, wbv_n, wbw_n, aderr_n, buserr_n;
    logic [31:0] addr_n, wdata_n, wbdata_n, load_val;
    logic [3:0]  be_n;
    logic [4:0]  wbd_n;
    logic [1:0]  in_size;
    logic        in_mis;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign Stall     = (state == REQ);
    assign dbg_state = state;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            lo_q     <= '0;
            dest_q   <= '0;
            rw_q     <= 1'b0;
            MemReq   <= 1'b0;
            MemWE    <= 1'b0;
            MemAddr  <= '0;
            MemBE    <= '0;
            MemWData <= '0;
            WbValid  <= 1'b0;
            WbWrite  <= 1'b0;
            WbDest   <= '0;
            WbData   <= '0;
            AdErr    <= 1'b0;
            BusErr   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            op_q     <= op_n;
            lo_q     <= lo_n;
            dest_q   <= dest_n;
            rw_q     <= rw_n;
            MemReq   <= req_n;
            MemWE    <= we_n;
            MemAddr  <= addr_n;
            MemBE    <= be_n;
            MemWData <= wdata_n;
            WbValid  <= wbv_n;
            WbWrite  <= wbw_n;
            WbDest   <= wbd_n;
            WbData   <= wbdata_n;
            AdErr    <= aderr_n;
            BusErr   <= buserr_n;
        end
    end

    always_comb begin
        sel_byte = MemRData[8*lo_q +: 8];
        sel_half = lo_q[1] ? MemRData[31:16] : MemRData[15:0];
        case (op_q)
            OP_LB:   load_val = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_val = {24'd0, sel_byte};
            OP_LH:   load_val = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_val = {16'd0, sel_half};
            OP_LW:   load_val = MemRData;
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        op_n     = op_q;
        lo_n     = lo_q;
        dest_n   = dest_q;
        rw_n     = rw_q;
        req_n    = MemReq;
        we_n     = MemWE;
        addr_n   = MemAddr;
        be_n     = MemBE;
        wdata_n  = MemWData;
        wbv_n    = 1'b0;
        wbw_n    = 1'b0;
        wbd_n    = WbDest;
        wbdata_n = WbData;
        aderr_n  = 1'b0;
        buserr_n = 1'b0;
        in_size  = op_size(InOp);
        in_mis   = ((in_size == 2'd1) && ALUOut[0]) ||
                   ((in_size == 2'd2) && (ALUOut[1:0] != 2'b00));

        case (state)
            IDLE: begin
                if (InValid) begin
                    if (!is_mem(InOp)) begin
                        wbv_n    = 1'b1;
                        wbd_n    = Dest;
                        wbdata_n = ALUOut;
                        wbw_n    = RegWrite && ALUEn && (Dest != 5'd0);
                    end else if (in_mis) begin
                        wbv_n    = 1'b1;
                        wbd_n    = Dest;
                        wbdata_n = ALUOut;
                        aderr_n  = 1'b1;
                    end else begin
                        state_n = REQ;
                        cnt_n   = '0;
                        op_n    = InOp;
                        lo_n    = ALUOut[1:0];
                        dest_n  = Dest;
                        rw_n    = RegWrite;
                        req_n   = 1'b1;
                        we_n    = InOp[3];
                        addr_n  = {ALUOut[31:2], 2'b00};
                        case (in_size)
                            2'd0:    be_n = 4'b0001 << ALUOut[1:0];
                            2'd1:    be_n = ALUOut[1] ? 4'b1100 : 4'b0011;
                            default: be_n = 4'b1111;
                        endcase
                        if (!InOp[3])
                            wdata_n = 32'd0;
                        else if (in_size == 2'd0)
                            wdata_n = {4{StoreData[7:0]}};
                        else if (in_size == 2'd1)
                            wdata_n = {2{StoreData[15:0]}};
                        else
                            wdata_n = StoreData;
                    end
                end
            end
            REQ: begin
                // Ack takes priority over the timeout in the final cycle.
                if (MemAck || (cnt == TO_LAST)) begin
                    state_n  = IDLE;
                    req_n    = 1'b0;
                    we_n     = 1'b0;
                    addr_n   = '0;
                    be_n     = '0;
                    wdata_n  = '0;
                    wbv_n    = 1'b1;
                    wbd_n    = dest_q;
                    if (MemAck) begin
                        wbdata_n = load_val;
                        wbw_n    = !op_q[3] && rw_q && (dest_q != 5'd0);
                    end else begin
                        wbdata_n = 32'd0;
                        buserr_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load extension, store lanes,
// misalignment, timeout abort and reset during a transaction.
module tb_mem_stage;
    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        InValid = 1'b0;
    logic [3:0]  InOp = 4'd0;
    logic [31:0] ALUOut = 32'd0;
    logic        ALUEn = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  Dest = 5'd0;
    logic [31:0] StoreData = 32'd0;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = 32'd0;
    logic        Stall, MemReq, MemWE, WbValid, WbWrite, AdErr, BusErr, dbg_state;
    logic [31:0] MemAddr, MemWData, WbData;
    logic [3:0]  MemBE;
    logic [4:0]  WbDest;

    int n_checks = 0;
    int n_fails  = 0;

    mem_stage #(.MEM_TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InOp(InOp), .ALUOut(ALUOut),
        .ALUEn(ALUEn), .RegWrite(RegWrite), .Dest(Dest), .StoreData(StoreData),
        .Stall(Stall), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
        .MemBE(MemBE), .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData),
        .WbValid(WbValid), .WbWrite(WbWrite), .WbDest(WbDest), .WbData(WbData),
        .AdErr(AdErr), .BusErr(BusErr), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [4:0] d,
                         input logic rw, input logic aen, input logic [31:0] sd);
        InValid = 1'b1; InOp = op; ALUOut = a; Dest = d;
        RegWrite = rw; ALUEn = aen; StoreData = sd;
    endtask

    // Issues a memory op (Dest 7, RegWrite 1, ALUEn 0), checks the held request each
    // REQ cycle, acks in REQ cycle ack_at (0 = never), and stops on the writeback cycle.
    task automatic mem_txn(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wd, input logic e_we);
        int last;
        issue(op, a, 5'd7, 1'b1, 1'b0, sd);
        MemRData = rd;
        tick();
        InValid = 1'b0;
        last = (ack_at == 0) ? TO : ack_at;
        for (int c = 1; c <= last; c++) begin
            check({tag, "_req_hi"}, MemReq, 1);
            check({tag, "_stall_hi"}, Stall, 1);
            check({tag, "_addr"}, MemAddr, e_addr);
            check({tag, "_be"}, MemBE, e_be);
            check({tag, "_wdata"}, MemWData, e_wd);
            check({tag, "_we"}, MemWE, e_we);
            check({tag, "_wbv_lo"}, WbValid, 0);
            if (c == ack_at) MemAck = 1'b1;
            tick();
            MemAck = 1'b0;
        end
        check({tag, "_req_lo"}, MemReq, 0);
        check({tag, "_stall_lo"}, Stall, 0);
        check({tag, "_wbv"}, WbValid, 1);
        check({tag, "_wbdest"}, WbDest, 7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a NONE instruction presented
        issue(4'b0000, 32'h0000_002A, 5'd3, 1'b1, 1'b1, 32'd0);
        tick();
        tick();
        check("rst_stall", Stall, 0);
        check("rst_state", dbg_state, 0);
        check("rst_memreq", MemReq, 0);
        check("rst_memwe", MemWE, 0);
        check("rst_memaddr", MemAddr, 0);
        check("rst_membe", MemBE, 0);
        check("rst_memwdata", MemWData, 0);
        check("rst_wbvalid", WbValid, 0);
        check("rst_wbwrite", WbWrite, 0);
        check("rst_wbdest", WbDest, 0);
        check("rst_wbdata", WbData, 0);
        check("rst_aderr", AdErr, 0);
        check("rst_buserr", BusErr, 0);
        Rst = 1'b0;

        tick();
        check("none_wbv", WbValid, 1);
        check("none_data", WbData, 32'h2A);
        check("none_dest", WbDest, 3);
        check("none_wbw", WbWrite, 1);
        check("none_stall", Stall, 0);

        issue(4'b0000, 32'h0000_1111, 5'd4, 1'b1, 1'b0, 32'd0);
        tick();
        check("movn_wbv", WbValid, 1);
        check("movn_wbw", WbWrite, 0);
        check("movn_data", WbData, 32'h1111);

        issue(4'b0111, 32'h0000_2222, 5'd0, 1'b1, 1'b1, 32'd0);
        tick();
        check("dest0_wbv", WbValid, 1);
        check("dest0_wbw", WbWrite, 0);
        check("dest0_data", WbData, 32'h2222);

        InValid = 1'b0;
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        check("idle_ack_wbv", WbValid, 0);
        check("idle_ack_req", MemReq, 0);
        check("idle_ack_stall", Stall, 0);

        mem_txn("lb", 4'b0001, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1,
                32'h0000_1000, 4'b1000, 32'd0, 1'b0);
        check("lb_data", WbData, 32'hFFFF_FF80);
        check("lb_wbw", WbWrite, 1);
        check("lb_buserr", BusErr, 0);

        mem_txn("lbu", 4'b0010, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1,
                32'h0000_1000, 4'b1000, 32'd0, 1'b0);
        check("lbu_data", WbData, 32'h0000_0080);

        mem_txn("lh", 4'b0011, 32'h0000_0602, 32'd0, 32'h8001_7FFF, 2,
                32'h0000_0600, 4'b1100, 32'd0, 1'b0);
        check("lh_data", WbData, 32'hFFFF_8001);

        mem_txn("lhu", 4'b0100, 32'h0000_0600, 32'd0, 32'h8001_F00D, 1,
                32'h0000_0600, 4'b0011, 32'd0, 1'b0);
        check("lhu_data", WbData, 32'h0000_F00D);

        mem_txn("sh", 4'b1010, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 3,
                32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1'b1);
        check("sh_wbw", WbWrite, 0);
        check("sh_buserr", BusErr, 0);

        mem_txn("sb", 4'b1001, 32'h0000_5001, 32'h0000_0077, 32'd0, 1,
                32'h0000_5000, 4'b0010, 32'h7777_7777, 1'b1);
        check("sb_wbw", WbWrite, 0);

        mem_txn("sw", 4'b1011, 32'h0000_5004, 32'hCAFE_F00D, 32'd0, 2,
                32'h0000_5004, 4'b1111, 32'hCAFE_F00D, 1'b1);
        check("sw_wbw", WbWrite, 0);

        issue(4'b0101, 32'h0000_3001, 5'd9, 1'b1, 1'b1, 32'd0);
        tick();
        check("lw_mis_req", MemReq, 0);
        check("lw_mis_stall", Stall, 0);
        check("lw_mis_aderr", AdErr, 1);
        check("lw_mis_wbv", WbValid, 1);
        check("lw_mis_wbw", WbWrite, 0);
        issue(4'b0011, 32'h0000_3001, 5'd9, 1'b1, 1'b1, 32'd0);
        tick();
        check("lh_mis_req", MemReq, 0);
        check("lh_mis_aderr", AdErr, 1);
        check("lh_mis_wbv", WbValid, 1);
        check("lh_mis_wbw", WbWrite, 0);
        InValid = 1'b0;
        tick();
        check("aderr_pulse", AdErr, 0);
        check("wbv_pulse", WbValid, 0);

        mem_txn("to", 4'b0101, 32'h0000_4000, 32'd0, 32'h1234_5678, 0,
                32'h0000_4000, 4'b1111, 32'd0, 1'b0);
        check("to_buserr", BusErr, 1);
        check("to_wbw", WbWrite, 0);
        tick();
        check("to_buserr_pulse", BusErr, 0);
        check("to_wbv_pulse", WbValid, 0);

        mem_txn("late_ack", 4'b0101, 32'h0000_4000, 32'd0, 32'hDEAD_BEEF, TO,
                32'h0000_4000, 4'b1111, 32'd0, 1'b0);
        check("late_ack_buserr", BusErr, 0);
        check("late_ack_data", WbData, 32'hDEAD_BEEF);
        check("late_ack_wbw", WbWrite, 1);

        issue(4'b0101, 32'h0000_4008, 5'd7, 1'b1, 1'b0, 32'd0);
        tick();
        InValid = 1'b0;
        check("rreq_req_hi", MemReq, 1);
        #2;
        Rst = 1'b1;
        #1;
        check("rreq_req_async", MemReq, 0);
        check("rreq_stall_async", Stall, 0);
        tick();
        Rst = 1'b0;
        tick();
        check("rreq_no_wbv", WbValid, 0);
        check("rreq_req_lo", MemReq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage sitting directly downstream of the ALU. It takes the ALU result as an effective address or pass-through value, runs load/store transactions on the data-memory port with a req/ack handshake, and sign- or zero-extends load data. It delivers one registered writeback record per accepted instruction and stalls upstream while a memory transaction is outstanding.

## Interface
- MEM_TIMEOUT, 255: number of MemReq cycles without MemAck before abort; legal range 1–255.

- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- InValid  in  1  instruction present from ALU stage.
- InOp  in  4  0000 NONE, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW, 1001 SB, 1010 SH, 1011 SW; any other code is treated as NONE.
- ALUOut  in  32  ALU result; effective address for memory ops.
- ALUEn  in  1  ALU write-enable (MOVN/MOVZ condition).
- RegWrite  in  1  instruction writes a register.
- Dest  in  5  destination register.
- StoreData  in  32  store source (rt).
- Stall  out  1  input not accepted this cycle.
- MemReq  out  1  memory request.
- MemWE  out  1  1 = store.
- MemAddr  out  32  word address; bits [1:0] are always 0.
- MemBE  out  4  byte enables, little-endian; byte 0 = bits [7:0].
- MemWData  out  32  store data.
- MemAck  in  1  request complete; MemRData valid in the same cycle.
- MemRData  in  32  read data.
- WbValid  out  1  writeback record valid; 1-cycle pulse.
- WbWrite  out  1  register write enable.
- WbDest  out  5  writeback register.
- WbData  out  32  writeback value.
- AdErr  out  1  misaligned-address pulse; coincides with WbValid.
- BusErr  out  1  memory-timeout pulse; coincides with WbValid.

## Operation
- States: IDLE, REQ. Stall = (state == REQ). An input is accepted on an edge where InValid=1 and Stall=0.
- Accept in IDLE, NONE: next edge WbValid=1, WbData=ALUOut, WbDest=Dest, WbWrite=RegWrite&ALUEn. State stays IDLE.
- Accept in IDLE, misaligned memory op (halfword with addr[0]=1, word with addr[1:0]≠0):
  - No memory access.
  - Next edge: WbValid=1, WbWrite=0, AdErr=1.
- Accept in IDLE, aligned memory op:
  - Latch op, address, Dest, RegWrite and store data; go to REQ.
  - MemAddr={addr[31:2],2'b00}.
  - SB: MemBE=1<<addr[1:0], MemWData={4{StoreData[7:0]}}.
  - SH: MemBE=addr[1]?1100:0011, MemWData={2{StoreData[15:0]}}.
  - SW: MemBE=1111, MemWData=StoreData.
  - Loads: MemBE as for the matching width, MemWData=0.
- REQ:
  - MemReq=1. MemWE, MemAddr, MemBE and MemWData are held stable until MemAck.
  - On the MemAck edge: WbValid=1 and the state returns to IDLE.
  - Loads on MemAck: select the addressed byte or halfword. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word. WbWrite=RegWrite.
  - Stores on MemAck: WbWrite=0.
- Timeout: an 8-bit counter is cleared on entry to REQ and increments each REQ cycle without MemAck. If MemAck=0 when the counter equals MEM_TIMEOUT-1, the transaction aborts: WbValid=1, WbWrite=0, BusErr=1, return to IDLE.
- MemAck wins if it arrives in the final timeout cycle.
- Dest=0 always forces WbWrite=0.
- MemAck while in IDLE is ignored.
- ALUEn is ignored for memory ops.

## Timing
- Reset: state IDLE, counter 0. Every output is 0: Stall, MemReq, MemWE, MemAddr, MemBE, MemWData, WbValid, WbWrite, WbDest, WbData, AdErr, BusErr.
- Reset asserted mid-REQ aborts immediately: MemReq drops asynchronously and no writeback is produced.
- All outputs are registered except Stall, which is decoded from the state register.
- NONE and misaligned ops: latency 1 cycle; sustained throughput is 1 per cycle.
- Aligned memory op accepted at edge N:
  - MemReq is high from cycle N+1.
  - MemAck in cycle N+k gives WbValid in cycle N+k+1.
  - Minimum latency is 2 cycles.
- Stall is high in cycles N+1..N+k and low in N+k+1, so the next instruction is accepted at the end of that cycle.
- Timeout: MemReq is high for exactly MEM_TIMEOUT cycles, then WbValid/BusErr follow in the next cycle.
- WbValid, AdErr and BusErr are high for exactly one cycle per record.

## Test plan
- Reset with InValid=1, NONE → all outputs 0. Release; ALUOut=0x0000_002A, Dest=3, RegWrite=1, ALUEn=1 → next cycle WbValid=1, WbData=0x2A, WbWrite=1.
- NONE with ALUEn=0 (MOVN false) → WbWrite=0. NONE with Dest=0 → WbWrite=0.
- LB at 0x1003, MemRData=0x80FF_0000, ack in the first REQ cycle:
  - MemAddr=0x1000, MemBE=1000.
  - WbData=0xFFFF_FF80, two cycles after accept.
  - LBU on the same data → 0x0000_0080.
- SH at 0x2002, StoreData=0x1234_ABCD, ack after 3 cycles:
  - MemWE=1, MemBE=1100, MemWData=0xABCD_ABCD.
  - Stall high for 3 cycles.
  - WbValid with WbWrite=0.
- LW at 0x3001 → no MemReq; next cycle AdErr=1, WbValid=1, WbWrite=0. LH at 0x3001 behaves the same.
- MEM_TIMEOUT=4, no ack → MemReq high exactly 4 cycles, then BusErr=1, WbWrite=0. Repeat with ack in the 4th cycle → normal completion, BusErr=0. Assert Rst during REQ → MemReq=0 immediately, no WbValid.
